wb_line_responder: RTL
======================

// Module: wb_line_responder
// PURPOSE
// - Wishbone classic-cycle slave. It serves full-line (DATA_WIDTH) reads and lane-masked writes from an internal RAM.
// - It is the responder for the CPU memory controller's line-wide master port (wb_*_o/wb_*_i).
// - Used as boot/scratch memory in simulation and FPGA top-levels.
// - Generates wait states, bus errors and, optionally, injected retries to exercise the master.
// PARAMETERS
// - DATA_WIDTH      128    line width in bits, equal to the master's CACHE_WIDTH
// - GRANULARITY     32     bits per address unit and per select lane
// - ADDR_WIDTH      32     address width
// - DEPTH_LOG2      10     log2 of the number of lines in the RAM
// - BASE_ADDR       0      first address unit decoded; must be line-aligned
// - WAIT_STATES     1      extra cycles between sampling the request and responding (0..15)
// - RTY_PERIOD      8      with WB_RESP_RTY_EN, every RTY_PERIOD-th valid access gets rty (>=2)
// - localparam SEL_WIDTH = DATA_WIDTH/GRANULARITY
// - localparam LSB = log2(SEL_WIDTH), the address-unit bits inside a line
// PORTS
// - clk       in   1           clock, all state on rising edge
// - rst       in   1           reset, asynchronous, active-low
// - wb_cyc_i  in   1           bus cycle active
// - wb_stb_i  in   1           strobe / transfer request
// - wb_we_i   in   1           1 = write, 0 = read
// - wb_adr_i  in   ADDR_WIDTH  address in GRANULARITY units
// - wb_sel_i  in   SEL_WIDTH   write lane enables; lane k = bits [k*G +: G]
// - wb_dat_i  in   DATA_WIDTH  write data
// - wb_dat_o  out  DATA_WIDTH  read data, valid while wb_ack_o=1 on a read
// - wb_ack_o  out  1           normal termination
// - wb_err_o  out  1           error termination
// - wb_rty_o  out  1           retry termination
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE; ack/err/rty=0; dat_o=0; wait counter=0; retry counter=0. RAM contents are not reset.
// - At most one of ack/err/rty is high in any cycle. Each is a single-cycle pulse. No pipelined mode: stall is never driven.
// - FSM IDLE -> WAIT -> RESP -> IDLE:
//   - IDLE: on cyc&stb, latch we, adr, sel and dat_i. Classify the access, then go to WAIT if WAIT_STATES>0, else RESP.
//   - WAIT: count down WAIT_STATES cycles, then go to RESP.
//   - RESP: drive the one-cycle termination for the latched class, then return to IDLE.
// - Latency: request sampled at edge T gives termination high in cycle T+1+WAIT_STATES.
// - Back-to-back: if stb is still high in the cycle after RESP, IDLE samples it as a new transfer.
//   Minimum spacing is therefore 2+WAIT_STATES cycles per transfer.
// - Classification, highest priority first:
//   - err: adr[LSB-1:0]!=0 (misaligned) or adr outside [BASE_ADDR, BASE_ADDR + 2^DEPTH_LOG2 * SEL_WIDTH).
//   - rty (macro only): see CONFIGURATION.
//   - otherwise ok.
// - Index = (adr - BASE_ADDR) >> LSB, width DEPTH_LOG2; range is already checked, so there is no wrap.
// - Write ok: in the RESP cycle, lanes with sel=1 take dat_i; other lanes keep their value; ack=1. sel=0 still acks and changes nothing.
// - Read ok: RAM is read at the RESP edge. dat_o holds the line during the ack cycle and keeps its value afterwards. sel is ignored on reads.
// - err/rty: RAM is unchanged and dat_o keeps its previous value.
// - Abort: if cyc_i=0 in WAIT or RESP, go to IDLE next edge with no termination and no write committed.
//   The retry counter does not advance on an aborted access.
// - stb=0 with cyc=1 in IDLE: stay IDLE.
// - Inputs are not re-sampled after IDLE; changes to them mid-transfer are ignored.
// CONFIGURATION
// - Macro WB_RESP_RTY_EN:
//   - Defined: a counter (reset 0) increments on each non-err, non-aborted termination.
//     - When it reaches RTY_PERIOD-1, that access ends with rty instead of ack and no RAM access, and the counter wraps to 0.
//     - The master's retry of the same address is then a fresh access.
//   - Undefined: wb_rty_o is tied 0, the counter and RTY_PERIOD logic are absent, and every non-err access acks.
// TESTING
// - Reset mid-WAIT: assert rst=0 during WAIT of a write to adr 0x10.
//   -> All terminations 0 immediately; state IDLE; that line is unchanged on a later read.
// - Write then read, WAIT_STATES=1, BASE_ADDR=0:
//   - Write adr=0x8, sel=4'b1111, dat=128'h0123..CDEF -> ack in cycle T+2.
//   - Read adr=0x8 -> dat_o=128'h0123..CDEF with ack.
// - Lane mask:
//   - Fill line 0x4 with all-F.
//   - Write sel=4'b0101, dat=0 -> read returns 128'hFFFFFFFF_00000000_FFFFFFFF_00000000.
// - Errors:
//   - adr=0x6 (misaligned) -> err, no ack.
//   - adr=0x1000 (out of range for DEPTH_LOG2=10) -> err.
//   - RAM is unchanged in both cases.
// - Abort: drop cyc in WAIT of a write to 0xC -> no ack/err/rty ever; a subsequent read of 0xC returns the old data.
// - WB_RESP_RTY_EN, RTY_PERIOD=4: eight valid reads -> terminations ack,ack,ack,rty,ack,ack,ack,rty. An err access in between does not shift this pattern.

Source files
------------

// File: rtl/wb_line_responder_if.sv
// -----------------------------------------------------------------------------
// wb_line_responder_if
// Wishbone classic-cycle bundle between a line-wide master and the
// wb_line_responder slave. Signal names are taken from the slave's point of
// view (_i = into the slave, _o = out of the slave).
//
// Parameters
//   DATA_WIDTH   line width in bits
//   GRANULARITY  bits per address unit and per select lane
//   ADDR_WIDTH   address width in GRANULARITY units
//
// Signals
//   wb_cyc_i  bus cycle active           wb_dat_i  write data
//   wb_stb_i  transfer request           wb_dat_o  read data
//   wb_we_i   1 = write, 0 = read        wb_ack_o  normal termination
//   wb_adr_i  address                    wb_err_o  error termination
//   wb_sel_i  write lane enables         wb_rty_o  retry termination
// -----------------------------------------------------------------------------
interface wb_line_responder_if #(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned GRANULARITY = 32,
  parameter int unsigned ADDR_WIDTH  = 32
);
  localparam int unsigned SEL_WIDTH = DATA_WIDTH / GRANULARITY;

  logic                  wb_cyc_i;
  logic                  wb_stb_i;
  logic                  wb_we_i;
  logic [ADDR_WIDTH-1:0] wb_adr_i;
  logic [SEL_WIDTH-1:0]  wb_sel_i;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic                  wb_ack_o;
  logic                  wb_err_o;
  logic                  wb_rty_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/wb_line_responder.sv
// -----------------------------------------------------------------------------
// wb_line_responder
// Wishbone classic-cycle slave serving full-line reads and lane-masked writes
// from an internal RAM. Used as boot/scratch memory; it inserts wait states,
// flags bad addresses with err and can inject periodic retries.
//
// Ports
//   clk   clock, all state on the rising edge
//   rst   asynchronous active-low reset
//   wb    wb_line_responder_if.slave (cyc/stb/we/adr/sel/dat_i in,
//         dat_o/ack/err/rty out); terminations are single-cycle registered
//         pulses, dat_o is registered and holds the last line read.
//
// Optional feature (macro WB_RESP_RTY_EN)
//   Defined:   every RTY_PERIOD-th valid, non-aborted access ends with rty.
//   Undefined: wb_rty_o is tied low and every valid access acks.
//
// Timing: request sampled at edge T -> termination high in cycle
// T+1+WAIT_STATES. RAM contents are not reset.
// -----------------------------------------------------------------------------
module wb_line_responder #(
  parameter int unsigned           DATA_WIDTH  = 128,
  parameter int unsigned           GRANULARITY = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DEPTH_LOG2  = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 1,
  parameter int unsigned           RTY_PERIOD  = 8
) (
  input logic                clk,
  input logic                rst,
  wb_line_responder_if.slave wb
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / GRANULARITY;
  localparam int unsigned LSB       = $clog2(SEL_WIDTH);
  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  // Size of the decoded window in address units, one bit wider than the bus
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(1) << (DEPTH_LOG2 + LSB);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  we_q, we_d;
  logic                  acc_err_q, acc_err_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [DATA_WIDTH-1:0] dat_o_q, dat_o_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  ram_we_s;
  logic                  serve_s;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] adr_off_s;
  logic                  misaligned_s;
  logic                  in_range_s;

`ifdef WB_RESP_RTY_EN
  localparam int unsigned RCW = $clog2(RTY_PERIOD);
  logic [RCW-1:0] rty_cnt_q, rty_cnt_d;
  logic           rty_q, rty_d;
  logic           rty_hit_s;

  assign rty_hit_s = (rty_cnt_q == RCW'(RTY_PERIOD - 1));
`endif

  // Address decode of the live request; only consumed in IDLE
  assign adr_off_s    = wb.wb_adr_i - BASE_ADDR;
  assign misaligned_s = (wb.wb_adr_i[LSB-1:0] != {LSB{1'b0}});
  assign in_range_s   = (wb.wb_adr_i >= BASE_ADDR) && ({1'b0, adr_off_s} < SPAN);

  // Next-state, latching and termination logic
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    we_d       = we_q;
    acc_err_d  = acc_err_q;
    idx_d      = idx_q;
    sel_d      = sel_q;
    wdat_d     = wdat_q;
    dat_o_d    = dat_o_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    ram_we_s   = 1'b0;
    serve_s    = 1'b0;
`ifdef WB_RESP_RTY_EN
    rty_d      = 1'b0;
    rty_cnt_d  = rty_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (wb.wb_cyc_i && wb.wb_stb_i) begin
          we_d      = wb.wb_we_i;
          sel_d     = wb.wb_sel_i;
          wdat_d    = wb.wb_dat_i;
          idx_d     = adr_off_s[LSB +: DEPTH_LOG2];
          acc_err_d = misaligned_s || !in_range_s;
          if (WAIT_STATES > 0) begin
            state_d    = S_WAIT;
            wait_cnt_d = 4'(WAIT_STATES - 1);
          end else begin
            state_d    = S_RESP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WAIT: begin
        if (!wb.wb_cyc_i) begin
          // Master abandoned the cycle: no termination, nothing committed
          state_d    = S_IDLE;
          wait_cnt_d = 4'd0;
        end else if (wait_cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
        if (!wb.wb_cyc_i) begin
          // Late abort: drop silently, retry counter untouched
          serve_s = 1'b0;
        end else if (acc_err_q) begin
          err_d = 1'b1;
        end else begin
`ifdef WB_RESP_RTY_EN
          // Injected retry replaces the RAM access entirely
          serve_s   = !rty_hit_s;
          rty_d     = rty_hit_s;
          rty_cnt_d = rty_hit_s ? {RCW{1'b0}} : (rty_cnt_q + RCW'(1));
`else
          serve_s   = 1'b1;
`endif
          if (serve_s) begin
            ack_d = 1'b1;
            if (we_q) begin
              ram_we_s = 1'b1;
            end else begin
              dat_o_d = mem_q[idx_q];
            end
          end else begin
            ack_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, latched request and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 4'd0;
      we_q       <= 1'b0;
      acc_err_q  <= 1'b0;
      idx_q      <= {DEPTH_LOG2{1'b0}};
      sel_q      <= {SEL_WIDTH{1'b0}};
      wdat_q     <= {DATA_WIDTH{1'b0}};
      dat_o_q    <= {DATA_WIDTH{1'b0}};
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      we_q       <= we_d;
      acc_err_q  <= acc_err_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      wdat_q     <= wdat_d;
      dat_o_q    <= dat_o_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

`ifdef WB_RESP_RTY_EN
  // Retry period counter and retry pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rty_cnt_q <= {RCW{1'b0}};
      rty_q     <= 1'b0;
    end else begin
      rty_cnt_q <= rty_cnt_d;
      rty_q     <= rty_d;
    end
  end

  assign wb.wb_rty_o = rty_q;
`else
  assign wb.wb_rty_o = 1'b0;
`endif

  // Lane-masked line write; RAM contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      for (int k = 0; k < SEL_WIDTH; k++) begin
        if (sel_q[k]) begin
          mem_q[idx_q][k*GRANULARITY +: GRANULARITY] <= wdat_q[k*GRANULARITY +: GRANULARITY];
        end
      end
    end
  end

  assign wb.wb_dat_o = dat_o_q;
  assign wb.wb_ack_o = ack_q;
  assign wb.wb_err_o = err_q;

endmodule
